// File: rtl/hsid_pkg.sv
// Shared types for the hsid FIFO write-side arbitration logic.
package hsid_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } hsid_arb_state_t;

endpackage

// File: rtl/hsid_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping to 0.
module hsid_rr_pick
  import hsid_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               any_o,
  output logic [IW-1:0]      idx_o
);

  int unsigned j;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[j[IW-1:0]]) begin
        any_o = 1'b1;
        idx_o = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/hsid_fifo_wr_arb.sv
// Round-robin burst arbiter sharing one hsid_fifo write port between NUM_REQ producers.
module hsid_fifo_wr_arb
  import hsid_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  hsid_arb_state_t state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic            g_valid;
  logic            g_last;
  logic            xfer;
  logic            burst_end;

  hsid_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign g_valid   = req_valid[gnt_q];
  assign g_last    = req_last[gnt_q];
  assign xfer      = (state_q == ARB_BURST) && g_valid && !fifo_full;
  // A dropped valid releases the grant without a transfer; a full FIFO only stalls.
  assign burst_end = (state_q == ARB_BURST) &&
                     (!g_valid || (xfer && (g_last || cnt_q == CW'(MAX_BURST - 1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any && !fifo_almost_full && !fifo_full) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (xfer) cnt_d = cnt_q + 1'b1;
        if (burst_end) begin
          ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    busy         = 1'b0;
    if (state_q == ARB_BURST) begin
      busy             = 1'b1;
      req_ready[gnt_q] = !fifo_full;
      fifo_wr_en       = g_valid && !fifo_full;
      fifo_data_in     = req_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_id = gnt_q;

endmodule

// File: tb/tb_hsid_fifo_wr_arb.sv
// Directed bench for hsid_fifo_wr_arb with a 16-deep FIFO model on the write port.
module tb_hsid_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic [1:0]  grant_id;
  logic        busy;

  logic        rd_en, pre_en, force_full;
  logic [7:0]  pre_data;
  logic [7:0]  mem[$];
  logic [7:0]  rdq[$];
  int          cnt = 0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          nb[4];
  logic [7:0]  base[4];
  int          lastat[4];
  logic        bad;

  hsid_fifo_wr_arb #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: depth 16, almost_full at 14 entries
  assign fifo_full        = force_full || (cnt >= 16);
  assign fifo_almost_full = (cnt >= 14);

  always @(posedge clk) begin
    if (rd_en && mem.size() > 0) rdq.push_back(mem.pop_front());
    if (fifo_wr_en && !fifo_full) mem.push_back(fifo_data_in);
    else if (pre_en) mem.push_back(pre_data);
    cnt <= mem.size();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = base[i] + nb[i][7:0];
      req_last[i]        = (nb[i] == lastat[i]);
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // One clock: advance each requester's beat index on an accepted beat.
  task automatic cyc();
    logic [3:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) nb[i]++;
    drive();
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      nb[i] = 0;
      lastat[i] = -1;
      base[i] = '0;
    end
    settle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    #1;
    repeat (n) cyc();
    rd_en = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; pre_en = 1'b0; force_full = 1'b0; pre_data = '0;
    req_data = '0; req_last = '0; req_valid = '0;
    for (int i = 0; i < 4; i++) begin nb[i] = 0; lastat[i] = -1; base[i] = '0; end
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_grant", grant_id, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;

    // single requester, 3-beat burst ending on last
    base[1] = 8'h10; lastat[1] = 2; req_valid = 4'b0010; settle();
    chk("t1_idle_ready", req_ready, 0);
    chk("t1_idle_busy", busy, 0);
    cyc();
    chk("t1_grant", grant_id, 1);
    chk("t1_busy", busy, 1);
    chk("t1_ready", req_ready, 4'b0010);
    chk("t1_wr_en", fifo_wr_en, 1);
    chk("t1_data0", fifo_data_in, 8'h10);
    cyc();
    chk("t1_data1", fifo_data_in, 8'h11);
    cyc();
    chk("t1_data2", fifo_data_in, 8'h12);
    cyc();
    chk("t1_end_busy", busy, 0);
    chk("t1_end_grant", grant_id, 1);
    chk("t1_end_wr", fifo_wr_en, 0);
    req_valid = '0; settle();
    chk("t1_count", cnt, 3);
    rdq.delete();
    drain(3);
    chk("t1_rd0", rdq[0], 8'h10);
    chk("t1_rd1", rdq[1], 8'h11);
    chk("t1_rd2", rdq[2], 8'h12);

    // release on dropped valid; pointer now at 2
    clr();
    base[2] = 8'h20; base[3] = 8'h30; lastat[3] = 1; req_valid = 4'b1100; settle();
    cyc();
    chk("t4_grant2", grant_id, 2);
    chk("t4_busy", busy, 1);
    chk("t4_data", fifo_data_in, 8'h20);
    cyc();
    cyc();
    req_valid[2] = 1'b0; settle();
    chk("t4_drop_wr", fifo_wr_en, 0);
    chk("t4_drop_busy", busy, 1);
    cyc();
    chk("t4_rel_busy", busy, 0);
    chk("t4_rel_grant", grant_id, 2);
    cyc();
    chk("t4_grant3", grant_id, 3);
    chk("t4_busy3", busy, 1);
    chk("t4_data3", fifo_data_in, 8'h30);
    cyc();
    cyc();
    chk("t4_end_busy", busy, 0);
    req_valid = '0; settle();
    chk("t4_count", cnt, 4);
    rdq.delete();
    drain(4);
    chk("t4_rd0", rdq[0], 8'h20);
    chk("t4_rd1", rdq[1], 8'h21);
    chk("t4_rd2", rdq[2], 8'h30);
    chk("t4_rd3", rdq[3], 8'h31);

    // all requesters streaming, max-length bursts until FIFO full
    clr();
    do_reset();
    for (int i = 0; i < 4; i++) base[i] = 8'(i * 16);
    req_valid = 4'b1111; settle();
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if ($countones(req_ready) > 1) bad = 1'b1;
      cyc();
    end
    chk("t2_onehot_ready", bad, 0);
    chk("t2_count", cnt, 16);
    chk("t2_full", fifo_full, 1);
    chk("t2_busy", busy, 0);
    for (int i = 0; i < 4; i++) chk("t2_beats", nb[i], 4);
    req_valid = '0; settle();
    rdq.delete();
    drain(16);
    for (int k = 0; k < 16; k++) chk("t2_order", rdq[k], 8'((k / 4) * 16 + (k % 4)));

    // almost_full blocks grant; in-flight burst stalls at full
    clr();
    do_reset();
    pre_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      pre_data = 8'hA0 + 8'(i);
      cyc();
    end
    pre_en = 1'b0; #1;
    chk("t3_pre_count", cnt, 14);
    chk("t3_af", fifo_almost_full, 1);
    base[0] = 8'h50; req_valid = 4'b0001; settle();
    repeat (3) cyc();
    chk("t3_af_busy", busy, 0);
    chk("t3_af_ready", req_ready, 0);
    chk("t3_af_wr", fifo_wr_en, 0);
    rd_en = 1'b1; #1; cyc(); rd_en = 1'b0; #1;
    chk("t3_cnt13", cnt, 13);
    chk("t3_still_idle", busy, 0);
    cyc();
    chk("t3_grant", grant_id, 0);
    chk("t3_busy", busy, 1);
    chk("t3_data", fifo_data_in, 8'h50);
    repeat (3) cyc();
    chk("t3_full", fifo_full, 1);
    chk("t3_stall_wr", fifo_wr_en, 0);
    chk("t3_stall_ready", req_ready, 0);
    chk("t3_stall_busy", busy, 1);
    repeat (2) cyc();
    chk("t3_held_busy", busy, 1);
    chk("t3_held_cnt", cnt, 16);
    rd_en = 1'b1; #1; cyc(); rd_en = 1'b0; #1;
    chk("t3_resume_wr", fifo_wr_en, 1);
    chk("t3_resume_data", fifo_data_in, 8'h53);
    cyc();
    chk("t3_end_busy", busy, 0);
    chk("t3_end_cnt", cnt, 16);
    chk("t3_beats", nb[0], 4);
    req_valid = '0; settle();
    rdq.delete();
    drain(16);
    for (int k = 0; k < 12; k++) chk("t3_pre_order", rdq[k], 8'hA2 + 8'(k));
    for (int k = 0; k < 4; k++) chk("t3_burst_order", rdq[12 + k], 8'h50 + 8'(k));

    // req_last while full: no transfer, burst held open; pointer now at 1
    clr();
    base[1] = 8'h60; lastat[1] = 0; req_valid = 4'b0010; settle();
    cyc();
    chk("t6_grant", grant_id, 1);
    chk("t6_wr", fifo_wr_en, 1);
    force_full = 1'b1; #1;
    chk("t6_full_wr", fifo_wr_en, 0);
    chk("t6_full_ready", req_ready, 0);
    cyc();
    chk("t6_hold_busy", busy, 1);
    chk("t6_hold_cnt", cnt, 0);
    cyc();
    chk("t6_hold_busy2", busy, 1);
    force_full = 1'b0; #1;
    chk("t6_resume_wr", fifo_wr_en, 1);
    chk("t6_resume_data", fifo_data_in, 8'h60);
    cyc();
    chk("t6_end_busy", busy, 0);
    chk("t6_cnt", cnt, 1);
    req_valid = '0; settle();
    rdq.delete();
    drain(1);
    chk("t6_rd", rdq[0], 8'h60);

    // reset during second beat of requester 1
    clr();
    base[1] = 8'h70; req_valid = 4'b0010; settle();
    cyc();
    chk("t5_grant", grant_id, 1);
    cyc();
    chk("t5_beat2", fifo_data_in, 8'h71);
    rst_n = 1'b0; #1;
    chk("t5_rst_wr", fifo_wr_en, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant_id, 0);
    base[0] = 8'h80; req_valid = 4'b0011; settle();
    cyc();
    rst_n = 1'b1; #1;
    chk("t5_post_busy", busy, 0);
    cyc();
    chk("t5_prio_grant", grant_id, 0);
    chk("t5_prio_busy", busy, 1);
    chk("t5_prio_data", fifo_data_in, 8'h80);
    req_valid = '0; settle();
    cyc();
    chk("t5_release", busy, 0);
    chk("t5_cnt", cnt, 1);
    rdq.delete();
    drain(1);
    chk("t5_rd", rdq[0], 8'h70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
